// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end: data width, the
// canonical NOP word and the fetch-stage state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC datapath: sequential and branch-target adders, PCSrc select and
// word-alignment detect on the selected address.
module pc_next_sel
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_pc_src,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic [XLEN-1:0] o_pc_target,
  output logic [XLEN-1:0] o_pc_next,
  output logic            o_misaligned
);

  // Both adders wrap modulo 2^32; overflow is architecturally ignored.
  assign o_pc_plus4   = i_pc + 32'd4;
  assign o_pc_target  = i_pc + i_imm;
  assign o_pc_next    = i_pc_src ? o_pc_target : o_pc_plus4;
  assign o_misaligned = |o_pc_next[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, requests words from instruction memory and holds
// each fetched instruction until the core accepts it.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       reset_n,
  output logic                       IMemReq,
  output logic [riscv_pkg::XLEN-1:0] IMemAddr,
  input  logic                       IMemReady,
  input  logic [riscv_pkg::XLEN-1:0] IMemRData,
  output logic [riscv_pkg::XLEN-1:0] Instr,
  output logic                       InstrValid,
  input  logic                       InstrAccept,
  input  logic                       PCSrc,
  input  logic [riscv_pkg::XLEN-1:0] ImmExt,
  output logic [riscv_pkg::XLEN-1:0] PC,
  output logic [riscv_pkg::XLEN-1:0] PCPlus4,
  output logic [riscv_pkg::XLEN-1:0] PCTarget,
  output logic                       MisalignedErr,
  output riscv_pkg::fetch_state_t    o_dbg_state
);
  import riscv_pkg::*;

  // Memory side: IMemReq/IMemAddr is a request that stays asserted and stable
  // until IMemReady; a word transfers on any edge where both are high.
  // Core side: Instr/InstrValid is held until InstrAccept; the instruction
  // retires on any edge where InstrValid and InstrAccept are both high.

  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_instr_valid;
  logic            r_imem_req;
  logic            r_misaligned_err;

  logic [XLEN-1:0] w_pc_next;
  logic            w_misaligned;

  pc_next_sel u_pc_next_sel (
    .i_pc         (r_pc),
    .i_imm        (ImmExt),
    .i_pc_src     (PCSrc),
    .o_pc_plus4   (PCPlus4),
    .o_pc_target  (PCTarget),
    .o_pc_next    (w_pc_next),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= IDLE;
      r_pc             <= RESET_PC_ALIGNED;
      r_instr          <= NOP_INSTR;
      r_instr_valid    <= 1'b0;
      r_imem_req       <= 1'b0;
      r_misaligned_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_imem_req <= 1'b1;
          r_state    <= FETCH;
        end
        FETCH: begin
          if (IMemReady) begin
            r_instr       <= IMemRData;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= HOLD;
          end
        end
        HOLD: begin
          if (InstrAccept) begin
            // A misaligned target freezes PC/Instr for post-mortem inspection.
            if (w_misaligned) begin
              r_misaligned_err <= 1'b1;
              r_instr_valid    <= 1'b0;
              r_state          <= FAULT;
            end else begin
              r_pc          <= w_pc_next;
              r_instr       <= NOP_INSTR;
              r_instr_valid <= 1'b0;
              r_imem_req    <= 1'b1;
              r_state       <= FETCH;
            end
          end
        end
        FAULT: begin
          r_state <= FAULT;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign IMemReq       = r_imem_req;
  assign IMemAddr      = r_pc;
  assign PC            = r_pc;
  assign Instr         = r_instr;
  assign InstrValid    = r_instr_valid;
  assign MisalignedErr = r_misaligned_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: walks reset, memory wait, stall,
// sequential/branch/wrap PC updates, misalignment fault and async reset.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  logic         clk;
  logic         reset_n;
  logic         IMemReq;
  logic [31:0]  IMemAddr;
  logic         IMemReady;
  logic [31:0]  IMemRData;
  logic [31:0]  Instr;
  logic         InstrValid;
  logic         InstrAccept;
  logic         PCSrc;
  logic [31:0]  ImmExt;
  logic [31:0]  PC;
  logic [31:0]  PCPlus4;
  logic [31:0]  PCTarget;
  logic         MisalignedErr;
  fetch_state_t dbg_state;

  int n_vec;
  int n_err;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .IMemReq       (IMemReq),
    .IMemAddr      (IMemAddr),
    .IMemReady     (IMemReady),
    .IMemRData     (IMemRData),
    .Instr         (Instr),
    .InstrValid    (InstrValid),
    .InstrAccept   (InstrAccept),
    .PCSrc         (PCSrc),
    .ImmExt        (ImmExt),
    .PC            (PC),
    .PCPlus4       (PCPlus4),
    .PCTarget      (PCTarget),
    .MisalignedErr (MisalignedErr),
    .o_dbg_state   (dbg_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no end of stimulus expected completion");
    $fatal(1, "bench time limit expired");
  end

  // Checking
  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] addr);
    check_val({tag, "_state"}, 32'(dbg_state), 32'(FETCH));
    check_val({tag, "_req"},   32'(IMemReq), 32'd1);
    check_val({tag, "_addr"},  IMemAddr, addr);
    check_val({tag, "_valid"}, 32'(InstrValid), 32'd0);
    check_val({tag, "_instr"}, Instr, NOP);
  endtask

  task automatic check_hold(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    check_val({tag, "_state"}, 32'(dbg_state), 32'(HOLD));
    check_val({tag, "_req"},   32'(IMemReq), 32'd0);
    check_val({tag, "_valid"}, 32'(InstrValid), 32'd1);
    check_val({tag, "_pc"},    PC, pc);
    check_val({tag, "_instr"}, Instr, ins);
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic src, input logic [31:0] imm);
    PCSrc       = src;
    ImmExt      = imm;
    InstrAccept = 1'b1;
    step();
    InstrAccept = 1'b0;
    PCSrc       = 1'($urandom_range(0, 1));
    ImmExt      = $urandom;
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    check_val({tag, "_req"},   32'(IMemReq), 32'd0);
    check_val({tag, "_valid"}, 32'(InstrValid), 32'd0);
    check_val({tag, "_err"},   32'(MisalignedErr), 32'd0);
    check_val({tag, "_pc"},    PC, 32'h0);
    check_val({tag, "_instr"}, Instr, NOP);
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    reset_n     = 1'b0;
    IMemReady   = 1'b1;
    IMemRData   = 32'h0050_0093;
    InstrAccept = 1'b0;
    PCSrc       = 1'b0;
    ImmExt      = 32'h0;

    #12;
    check_reset_values("rst");
    reset_n = 1'b1;

    // IDLE for one edge even with IMemReady high, then fetch from 0.
    step();
    check_fetch("first_fetch", 32'h0);
    step();
    check_hold("first_hold", 32'h0, 32'h0050_0093);
    check_val("pcplus4_0", PCPlus4, 32'h4);

    // Memory wait at PC=4: request and address stay put, Instr untouched.
    IMemReady = 1'b0;
    IMemRData = 32'hDEAD_BEEF;
    accept(1'b0, 32'h0);
    check_fetch("seq_to_4", 32'h4);
    for (int i = 0; i < 3; i++) begin
      step();
      check_fetch($sformatf("wait%0d", i), 32'h4);
    end
    IMemReady = 1'b1;
    IMemRData = 32'h0000_0113;
    step();
    check_hold("wait_done", 32'h4, 32'h0000_0113);

    // Two-cycle stall, then sequential accept.
    IMemRData = 32'h0020_8113;
    for (int i = 0; i < 2; i++) begin
      step();
      check_hold($sformatf("stall%0d", i), 32'h4, 32'h0000_0113);
    end
    accept(1'b0, 32'h0);
    check_fetch("seq_to_8", 32'h8);
    step();
    check_hold("hold_8", 32'h8, 32'h0020_8113);
    accept(1'b0, 32'h0);
    check_fetch("seq_to_12", 32'hC);
    step();
    accept(1'b1, 32'h4);
    check_fetch("jump_to_10", 32'h10);
    step();
    check_hold("hold_10", 32'h10, 32'h0020_8113);

    // Backward branch with negative immediate.
    PCSrc  = 1'b1;
    ImmExt = 32'hFFFF_FFF8;
    #1;
    check_val("target_neg", PCTarget, 32'h8);
    accept(1'b1, 32'hFFFF_FFF8);
    check_fetch("branch_to_8", 32'h8);
    step();
    accept(1'b1, 32'h8);
    check_fetch("branch_to_10", 32'h10);
    step();

    // Misaligned target: fault, PC and Instr frozen.
    PCSrc  = 1'b1;
    ImmExt = 32'h0000_0006;
    #1;
    check_val("target_mis", PCTarget, 32'h16);
    accept(1'b1, 32'h0000_0006);
    check_val("fault_state", 32'(dbg_state), 32'(FAULT));
    check_val("fault_err",   32'(MisalignedErr), 32'd1);
    check_val("fault_req",   32'(IMemReq), 32'd0);
    check_val("fault_valid", 32'(InstrValid), 32'd0);
    check_val("fault_pc",    PC, 32'h10);
    check_val("fault_instr", Instr, 32'h0020_8113);
    step();
    check_val("fault_sticky_state", 32'(dbg_state), 32'(FAULT));
    check_val("fault_sticky_err",   32'(MisalignedErr), 32'd1);

    // Async reset out of FAULT, between edges.
    #3 reset_n = 1'b0;
    #1;
    check_reset_values("rst_fault");
    reset_n = 1'b1;

    // Wrap-around: PC=FFFF_FFFC + 4 = 0.
    step();
    check_fetch("refetch_0", 32'h0);
    step();
    accept(1'b1, 32'hFFFF_FFFC);
    check_fetch("jump_top", 32'hFFFF_FFFC);
    step();
    check_hold("hold_top", 32'hFFFF_FFFC, 32'h0020_8113);
    check_val("pcplus4_wrap", PCPlus4, 32'h0);
    accept(1'b0, 32'h0);
    check_fetch("wrap_to_0", 32'h0);

    // Async reset mid-FETCH at a nonzero PC, memory not ready.
    step();
    accept(1'b1, 32'h40);
    IMemReady = 1'b0;
    check_fetch("jump_40", 32'h40);
    step();
    check_fetch("wait_40", 32'h40);
    #3 reset_n = 1'b0;
    #1;
    check_reset_values("rst_fetch");
    check_val("rst_fetch_addr", IMemAddr, 32'h0);
    reset_n = 1'b1;

    // Async reset while holding an instruction drops InstrValid at once.
    IMemReady = 1'b1;
    IMemRData = 32'h00A0_0513;
    step();
    step();
    check_hold("hold_pre_rst", 32'h0, 32'h00A0_0513);
    #3 reset_n = 1'b0;
    #1;
    check_reset_values("rst_hold");
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream fetch stage of the RISC-V core.
- Holds the PC and issues word fetches to instruction memory over a req/ready handshake.
- Presents the fetched instruction word to the decoder and immediate extender (Instr[31:7] feeds the extender) under a valid/accept handshake.
- Consumes the extended immediate (ImmExt) and PCSrc to form the next PC for branches and jumps.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset; bits [1:0] are forced to 0.
- NOP_INSTR, 32'h0000_0013, value of Instr while no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- IMemReq  out  1  fetch request to instruction memory.
- IMemAddr  out  32  fetch address; always equals PC.
- IMemReady  in  1  memory has IMemRData valid this cycle; ignored unless IMemReq=1.
- IMemRData  in  32  fetched instruction word.
- Instr  out  32  held instruction word to the decoder and immediate extender.
- InstrValid  out  1  Instr is valid.
- InstrAccept  in  1  core has consumed Instr this cycle; ignored unless InstrValid=1.
- PCSrc  in  1  1 = take PCTarget, 0 = take PCPlus4; sampled only on accept.
- ImmExt  in  32  extended immediate for the held Instr.
- PC  out  32  address of the held or in-flight instruction.
- PCPlus4  out  32  PC + 4, combinational.
- PCTarget  out  32  PC + ImmExt, combinational.
- MisalignedErr  out  1  sticky fault flag.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-fetch):
  - state=IDLE, PC=RESET_PC with [1:0]=0, Instr=NOP_INSTR.
  - InstrValid=0, IMemReq=0, MisalignedErr=0.
- States: IDLE, FETCH, HOLD, FAULT.
- IDLE: IMemReq=0. Goes to FETCH unconditionally on the first clk edge after reset_n deasserts.
- FETCH: IMemReq=1, IMemAddr=PC.
  - Edge with IMemReady=1: Instr<=IMemRData, InstrValid<=1, go to HOLD.
  - Otherwise stay in FETCH. IMemReq stays high and IMemAddr stays stable until ready; the request is never withdrawn.
- HOLD: IMemReq=0, InstrValid=1, Instr and PC stable.
  - Edge with InstrAccept=1: next = PCSrc ? PCTarget : PCPlus4.
    - If next[1:0] != 0: go to FAULT; PC and Instr unchanged; MisalignedErr<=1.
    - Else: PC<=next, InstrValid<=0, Instr<=NOP_INSTR, go to FETCH.
  - Edge with InstrAccept=0: stay in HOLD (stall), any number of cycles.
- FAULT: IMemReq=0, InstrValid=0, MisalignedErr=1. Exit only via reset.
- Latency and throughput:
  - Ready in the first FETCH cycle gives InstrValid in the next cycle.
  - Accept in the first HOLD cycle gives IMemReq in the next cycle.
  - Best case is 2 cycles per instruction.
- Arithmetic is modulo 2^32 with no overflow detection. Examples: PCPlus4 of 32'hFFFF_FFFC is 0; PCTarget with negative ImmExt wraps.
- Misalignment is checked only on bits [1:0] of the selected next PC. The PCPlus4 path is always aligned by construction.
- PCSrc and ImmExt are don't-care outside the HOLD accept edge.
- IMemReady=1 while IMemReq=0 has no effect.

Decomposition:
- Shared package riscv_pkg:
  - XLEN=32.
  - NOP_INSTR constant.
  - fetch_state_t enum {IDLE, FETCH, HOLD, FAULT}.
- Sub-module pc_next_sel: combinational PCPlus4 adder, PCTarget adder, PCSrc mux and misalignment detect. Outputs: next PC and misaligned flag.
- FSM and registers stay in instr_fetch_unit.

Test Plan:
- Reset release with RESET_PC=0 and IMemReady tied 1 -> IDLE one cycle, then IMemReq=1 with IMemAddr=0. Next cycle InstrValid=1 and Instr equals IMemRData=32'h0050_0093.
- Memory wait: IMemReady=0 for 3 cycles in FETCH -> IMemReq held 1 and IMemAddr stable at 4 throughout. Instr captured only on the ready cycle.
- Stall then sequential accept: InstrAccept=0 for 2 cycles -> Instr and PC held. Accept with PCSrc=0 at PC=8 -> next IMemAddr=12.
- Branch taken: PC=32'h10, ImmExt=32'hFFFF_FFF8, PCSrc=1, accept -> next IMemAddr=32'h08. With ImmExt=32'h0000_0006: MisalignedErr=1, state FAULT, IMemReq=0, PC stays 32'h10.
- Wrap-around: PC=32'hFFFF_FFFC, accept with PCSrc=0 -> IMemAddr=0.
- Asynchronous reset mid-FETCH, asserted between edges -> IMemReq, InstrValid and MisalignedErr drop immediately; PC=RESET_PC without waiting for clk.
